// File: rtl/cnn_pkg.sv
// Shared frame geometry, pixel type and streamer state encoding for the CNN front end.
package cnn_pkg;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int PIX_W  = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NPIX);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WAIT,
        ST_START,
        ST_GAP,
        ST_STREAM,
        ST_DONE
    } strm_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Storage is never cleared; only the read-data register is reset.
module frame_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: host bytes land at the current load address.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one-cycle latency, holds the last word between reads.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Loads one frame from a host byte stream, then replays it to the CNN as a
// start pulse followed by a raster-order pixel stream.
module frame_pixel_streamer
    import cnn_pkg::*;
#(
    parameter int IMG_W     = cnn_pkg::IMG_W,
    parameter int IMG_H     = cnn_pkg::IMG_H,
    parameter int PIX_W     = cnn_pkg::PIX_W,
    parameter int START_GAP = 2,
    parameter int PIX_GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             cnn_busy,
    output logic             start_signal,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel_out,
    output logic             frame_done,
    output logic             err_frame,
    output logic [15:0]      frames_sent
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int AW    = $clog2(N_PIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);

    strm_state_t   state, state_nxt;
    logic [AW-1:0] wcnt, rcnt;
    logic [15:0]   gcnt, pcnt;
    logic          hs, last_byte, rd_en;

    assign hs        = s_valid && s_ready;
    assign last_byte = (wcnt == LAST_ADDR);
    // A read is issued whenever the inter-beat spacing counter has drained.
    assign rd_en     = (state == ST_STREAM) && (pcnt == 16'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic; a framing error on an early s_last keeps us in LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:   if (hs && last_byte)            state_nxt = ST_WAIT;
            ST_WAIT:   if (!cnn_busy)                  state_nxt = ST_START;
            ST_START:                                  state_nxt = ST_GAP;
            ST_GAP:    if (gcnt == 16'(START_GAP - 1)) state_nxt = ST_STREAM;
            ST_STREAM: if (rd_en && rcnt == LAST_ADDR) state_nxt = ST_DONE;
            ST_DONE:                                   state_nxt = ST_LOAD;
            default:                                   state_nxt = ST_LOAD;
        endcase
    end

    // Registered outputs and counters. s_ready tracks the next state so it is
    // already low in the cycle after the final byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready      <= 1'b1;
            start_signal <= 1'b0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            err_frame    <= 1'b0;
            frames_sent  <= '0;
            wcnt         <= '0;
            rcnt         <= '0;
            gcnt         <= '0;
            pcnt         <= '0;
        end else begin
            s_ready      <= (state_nxt == ST_LOAD);
            start_signal <= (state == ST_START);
            frame_done   <= (state == ST_DONE);
            pixel_valid  <= rd_en;
            // s_last must coincide exactly with the final byte of the frame.
            err_frame    <= hs && (s_last != last_byte);

            if (hs) wcnt <= (s_last || last_byte) ? '0 : wcnt + 1'b1;

            if (state == ST_START) begin
                rcnt <= '0;
                gcnt <= '0;
                pcnt <= '0;
            end
            if (state == ST_GAP) gcnt <= gcnt + 16'd1;

            if (rd_en) begin
                rcnt <= rcnt + 1'b1;
                pcnt <= 16'(PIX_GAP);
            end else if (pcnt != 16'd0) begin
                pcnt <= pcnt - 16'd1;
            end

            if (state == ST_DONE) frames_sent <= frames_sent + 16'd1;
        end
    end

    frame_ram #(
        .DEPTH (N_PIX),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (hs),
        .waddr (wcnt),
        .wdata (s_data),
        .re    (rd_en),
        .raddr (rcnt),
        .rdata (pixel_out)
    );

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer: default instance plus a gapped one.
module tb_frame_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_last, s_ready, cnn_busy;
    logic        start_signal, pixel_valid, frame_done, err_frame;
    logic [7:0]  s_data, pixel_out;
    logic [15:0] frames_sent;

    logic        g_rst, g_s_valid, g_s_last, g_s_ready, g_cnn_busy;
    logic        g_start_signal, g_pixel_valid, g_frame_done, g_err_frame;
    logic [7:0]  g_s_data, g_pixel_out;
    logic [15:0] g_frames_sent;

    frame_pixel_streamer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .cnn_busy(cnn_busy), .start_signal(start_signal),
        .pixel_valid(pixel_valid), .pixel_out(pixel_out), .frame_done(frame_done),
        .err_frame(err_frame), .frames_sent(frames_sent)
    );

    frame_pixel_streamer #(.START_GAP(1), .PIX_GAP(2)) dut_g (
        .clk(clk), .rst(g_rst), .s_valid(g_s_valid), .s_data(g_s_data), .s_last(g_s_last),
        .s_ready(g_s_ready), .cnn_busy(g_cnn_busy), .start_signal(g_start_signal),
        .pixel_valid(g_pixel_valid), .pixel_out(g_pixel_out), .frame_done(g_frame_done),
        .err_frame(g_err_frame), .frames_sent(g_frames_sent)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorders for each instance.
    int         n_start = 0, n_beats = 0, n_done = 0, n_err = 0, t_start = 0, t_done = 0;
    int         beat_cyc [8192];
    logic [7:0] beat_val [8192];
    always @(negedge clk) begin
        if (start_signal) begin n_start <= n_start + 1; t_start <= cyc; end
        if (pixel_valid && n_beats < 8192) begin
            beat_cyc[n_beats] <= cyc;
            beat_val[n_beats] <= pixel_out;
            n_beats <= n_beats + 1;
        end
        if (frame_done) begin n_done <= n_done + 1; t_done <= cyc; end
        if (err_frame) n_err <= n_err + 1;
    end

    int         g_n_start = 0, g_n_beats = 0, g_n_done = 0, g_t_start = 0, g_t_done = 0;
    int         g_beat_cyc [2048];
    logic [7:0] g_beat_val [2048];
    always @(negedge clk) begin
        if (g_start_signal) begin g_n_start <= g_n_start + 1; g_t_start <= cyc; end
        if (g_pixel_valid && g_n_beats < 2048) begin
            g_beat_cyc[g_n_beats] <= cyc;
            g_beat_val[g_n_beats] <= g_pixel_out;
            g_n_beats <= g_n_beats + 1;
        end
        if (g_frame_done) begin g_n_done <= g_n_done + 1; g_t_done <= cyc; end
    end

    // Byte i carries (i*mul + add)[7:0]; s_last on index last_pos (-1 = never).
    task automatic send_frame(input bit g, input int n, input int last_pos,
                              input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            if (g) begin
                g_s_valid = 1'b1; g_s_data = 8'(i * mul + add); g_s_last = (i == last_pos);
            end else begin
                s_valid = 1'b1; s_data = 8'(i * mul + add); s_last = (i == last_pos);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; g_s_valid = 1'b0; g_s_last = 1'b0;
    endtask

    task automatic wait_done(input bit g, input int base, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk); #1;
            if ((g ? g_n_done : n_done) > base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; g_rst = 1'b1; cnn_busy = 1'b0; g_cnn_busy = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        g_s_valid = 1'b0; g_s_last = 1'b0; g_s_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; g_rst = 1'b0;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_checks++; if (start_signal !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start_signal); end
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_valid: got %b expected 0", pixel_valid); end
        n_checks++; if (pixel_out !== 8'd0) begin n_fail++; $display("FAIL reset_pixel_out: got %h expected 00", pixel_out); end
        n_checks++; if (frame_done !== 1'b0 || err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", frame_done, err_frame); end
        n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames_sent: got %0d expected 0", frames_sent); end
        n_checks++; if (g_s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_g_s_ready: got %b expected 1", g_s_ready); end
    endtask

    // Common stream checks for the default instance: count, timing, data.
    task automatic test_basic;
        int bb, bs, be, bd, bad; bit ok;
        bb = n_beats; bs = n_start; be = n_err; bd = n_done;
        send_frame(1'b0, 1024, 1023, 1, 0);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b expected 0", s_ready); end
        wait_done(1'b0, bd, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no frame_done expected one"); end
        n_checks++; if (n_start - bs != 1) begin n_fail++; $display("FAIL basic_starts: got %0d expected 1", n_start - bs); end
        n_checks++; if (n_beats - bb != 1024) begin n_fail++; $display("FAIL basic_beats: got %0d expected 1024", n_beats - bb); end
        n_checks++; if (n_err != be) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", n_err - be); end
        n_checks++; if (beat_cyc[bb] != t_start + 3) begin n_fail++; $display("FAIL basic_first_beat: got T+%0d expected T+3", beat_cyc[bb] - t_start); end
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (beat_cyc[bb + k] != t_start + 3 + k || beat_val[bb + k] !== 8'(k)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_stream: got %0d bad beats expected 0", bad); end
        n_checks++; if (t_done != t_start + 1027) begin n_fail++; $display("FAIL basic_done_time: got T+%0d expected T+1027", t_done - t_start); end
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL basic_frames_sent: got %0d expected 1", frames_sent); end
    endtask

    task automatic test_busy_hold;
        int bb, bs, bd, bad, c; bit ok;
        bb = n_beats; bs = n_start; bd = n_done;
        cnn_busy = 1'b1;
        send_frame(1'b0, 1024, 1023, 3, 0);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || start_signal !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL busy_hold: got %0d bad cycles expected 0", bad); end
        @(posedge clk); #1;
        cnn_busy = 1'b0; c = cyc;
        wait_done(1'b0, bd, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: got no frame_done expected one"); end
        n_checks++; if (n_start - bs != 1 || t_start != c + 2) begin n_fail++; $display("FAIL busy_start: got %0d pulses at +%0d expected 1 at +2", n_start - bs, t_start - c); end
        bad = 0;
        for (int k = 0; k < 1024; k++) if (beat_val[bb + k] !== 8'(3 * k)) bad++;
        n_checks++; if (bad != 0 || n_beats - bb != 1024) begin n_fail++; $display("FAIL busy_stream: got %0d bad of %0d beats expected 0 of 1024", bad, n_beats - bb); end
        n_checks++; if (frames_sent !== 16'd2) begin n_fail++; $display("FAIL busy_frames_sent: got %0d expected 2", frames_sent); end
    endtask

    task automatic test_early_last;
        int bb, bs, be, bd, bad; bit ok;
        bb = n_beats; bs = n_start; be = n_err; bd = n_done;
        send_frame(1'b0, 100, 99, 1, 0);
        n_checks++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL early_err_pulse: got %b expected 1", err_frame); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL early_ready: got %b expected 1", s_ready); end
        repeat (6) @(negedge clk);
        #1;
        n_checks++; if (n_start != bs || n_err - be != 1) begin n_fail++; $display("FAIL early_no_start: got starts=%0d errs=%0d expected 0/1", n_start - bs, n_err - be); end
        send_frame(1'b0, 1024, 1023, -1, 255);
        wait_done(1'b0, bd, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL early_timeout: got no frame_done expected one"); end
        bad = 0;
        for (int k = 0; k < 1024; k++) if (beat_val[bb + k] !== 8'(255 - k)) bad++;
        n_checks++; if (bad != 0 || n_beats - bb != 1024) begin n_fail++; $display("FAIL early_stream: got %0d bad of %0d beats expected 0 of 1024", bad, n_beats - bb); end
        n_checks++; if (frames_sent !== 16'd3) begin n_fail++; $display("FAIL early_frames_sent: got %0d expected 3", frames_sent); end
    endtask

    task automatic test_missing_last;
        int bb, be, bd, bad; bit ok;
        bb = n_beats; be = n_err; bd = n_done;
        send_frame(1'b0, 1024, -1, 1, 165);
        n_checks++; if (err_frame !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL nolast_err: got err=%b ready=%b expected 1/0", err_frame, s_ready); end
        wait_done(1'b0, bd, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nolast_timeout: got no frame_done expected one"); end
        bad = 0;
        for (int k = 0; k < 1024; k++) if (beat_val[bb + k] !== 8'(k + 165)) bad++;
        n_checks++; if (bad != 0 || n_beats - bb != 1024 || n_err - be != 1) begin n_fail++; $display("FAIL nolast_stream: got %0d bad of %0d beats errs=%0d expected 0 of 1024 errs=1", bad, n_beats - bb, n_err - be); end
        n_checks++; if (frames_sent !== 16'd4) begin n_fail++; $display("FAIL nolast_frames_sent: got %0d expected 4", frames_sent); end
    endtask

    task automatic test_gapped;
        int bb, bd, bad; bit ok;
        bb = g_n_beats; bd = g_n_done;
        send_frame(1'b1, 1024, 1023, 1, 0);
        wait_done(1'b1, bd, 5000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gap_timeout: got no frame_done expected one"); end
        n_checks++; if (g_n_beats - bb != 1024) begin n_fail++; $display("FAIL gap_beats: got %0d expected 1024", g_n_beats - bb); end
        n_checks++; if (g_beat_cyc[bb] != g_t_start + 2) begin n_fail++; $display("FAIL gap_first_beat: got T+%0d expected T+2", g_beat_cyc[bb] - g_t_start); end
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (g_beat_cyc[bb + k] != g_t_start + 2 + 3 * k || g_beat_val[bb + k] !== 8'(k)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL gap_stream: got %0d bad beats expected 0", bad); end
        n_checks++; if (g_t_done != g_t_start + 2 + 3 * 1023 + 1) begin n_fail++; $display("FAIL gap_done_time: got T+%0d expected T+3072", g_t_done - g_t_start); end
        n_checks++; if (g_frames_sent !== 16'd1) begin n_fail++; $display("FAIL gap_frames_sent: got %0d expected 1", g_frames_sent); end
    endtask

    task automatic test_reset_mid_stream;
        int bb, bd, bad; bit ok;
        bb = n_beats;
        send_frame(1'b0, 1024, 1023, 1, 0);
        ok = 1'b0;
        repeat (2000) begin
            @(negedge clk); #1;
            if (n_beats - bb >= 300) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout: got %0d beats expected 300", n_beats - bb); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        // Reset clears the frame counter along with everything else.
        n_checks++; if (pixel_valid !== 1'b0 || s_ready !== 1'b1 || frames_sent !== 16'd0) begin n_fail++; $display("FAIL midrst_outputs: got valid=%b ready=%b sent=%0d expected 0/1/0", pixel_valid, s_ready, frames_sent); end
        bb = n_beats; bd = n_done;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if (n_beats != bb || n_done != bd) begin n_fail++; $display("FAIL midrst_quiet: got %0d beats %0d dones expected 0/0", n_beats - bb, n_done - bd); end
        send_frame(1'b0, 1024, 1023, 1, 7);
        wait_done(1'b0, bd, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_new_timeout: got no frame_done expected one"); end
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (beat_cyc[bb + k] != t_start + 3 + k || beat_val[bb + k] !== 8'(k + 7)) bad++;
        n_checks++; if (bad != 0 || n_beats - bb != 1024) begin n_fail++; $display("FAIL midrst_stream: got %0d bad of %0d beats expected 0 of 1024", bad, n_beats - bb); end
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL midrst_frames_sent: got %0d expected 1", frames_sent); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_busy_hold;
        test_early_last;
        test_missing_last;
        test_gapped;
        test_reset_mid_stream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
